hash_transmitter: RTL and testbench
===================================

Name: hash_transmitter

Overview:
- Serialises a 64-bit hash value onto an 8-bit byte bus, most-significant byte first, one byte per clock.
- Raises a completion flag Z when the last byte has been sent.
- Sits between the string-hash generator (source of hashValue) and the byte-wide link/receiver.
- One transmission per reset release; the next transmission requires a new reset pulse.

Parameters:
- HASH_WIDTH, 64, width of hashValue; must be a multiple of BYTE_WIDTH.
- BYTE_WIDTH, 8, width of the output byte bus.
- NUM_BYTES, HASH_WIDTH/BYTE_WIDTH (8), derived localparam: bytes per transmission.

Ports:
- Clock  input  1  single system clock, rising-edge active.
- Reset  input  1  asynchronous, active-high reset; its deassertion starts a transmission.
- hashValue  input  HASH_WIDTH  value to transmit; sampled once at transmission start.
- Byte  output  BYTE_WIDTH  current transmitted byte; 0 when not sending.
- Z  output  1  done flag; 1 after all NUM_BYTES have been sent, held until Reset.

Behaviour:
- One clock domain. Reset is asynchronous and active-high. Named Clock/Reset as above.
- Reset asserted (any time, including mid-transmission):
  - state returns to IDLE immediately;
  - shift register, counter, Byte and Z are cleared to 0.
- States: IDLE, SEND, DONE.
- IDLE (Reset low): on the first rising edge, latch hashValue into a HASH_WIDTH shift register, clear the byte counter and go to SEND.
- SEND:
  - Byte = shift register[HASH_WIDTH-1 -: BYTE_WIDTH], so the MSB byte goes first.
  - Each rising edge shifts the register left by BYTE_WIDTH and increments the counter.
  - When the counter reaches NUM_BYTES-1, the next edge goes to DONE.
  - SEND lasts exactly NUM_BYTES cycles.
- DONE:
  - Byte = 0 and Z = 1.
  - Stays in DONE indefinitely and ignores hashValue until Reset is asserted.
- Latency:
  - Byte 0 (MSB) appears after the 1st rising edge following Reset deassertion.
  - Byte k appears after edge k+1.
  - Z rises after edge NUM_BYTES+1 (edge 9 with the defaults).
- Outputs are driven from registered state only: Byte through a mux of the state and shift register, Z decoded from state. No combinational path from hashValue to the outputs.
- Changes to hashValue during SEND or DONE have no effect on the byte stream. Leading zero bytes are transmitted as 0x00 (no suppression).
- Reset released and re-asserted within the same cycle window: the asynchronous clear wins; no partial byte is held.
- Counter width: clog2(NUM_BYTES) bits; no wrap occurs, because DONE is terminal.

Decomposition:
- Shared package (e.g. tx_pkg):
  - typedef of the state enum {IDLE, SEND, DONE};
  - constants HASH_WIDTH=64, BYTE_WIDTH=8, NUM_BYTES.
- No sub-module: the shift register, counter and FSM fit in one module.

Test Plan:
1. Reset high 80 ns, hashValue=64'h0000_0652_A553_28CA, clock 100 ns period, release Reset.
   - Byte sequence on edges 1–8: 00,00,06,52,A5,53,28,CA.
   - Z=0 throughout SEND; Z=1 after edge 9; Byte=0 in DONE.
2. After 1000 ns assert Reset and set hashValue=64'h0000_D0AB_8903_9614, release after 100 ns.
   - Z and Byte clear immediately on Reset.
   - Next stream: 00,00,D0,AB,89,03,96,14, then Z=1.
3. Repeat with 64'h0000_D0A7_798B_0879.
   - Stream: 00,00,D0,A7,79,8B,08,79, then Z=1.
   - Z stays 1 for 20+ further cycles.
4. Change hashValue to 64'hFFFF_FFFF_FFFF_FFFF after edge 3 of a transmission of 64'h0102_0304_0506_0708.
   - Stream is unchanged: 01..08.
5. Assert Reset asynchronously (between clock edges) during byte 4.
   - Byte=0 and Z=0 immediately, without waiting for a clock edge.
   - After release, the full 8-byte stream restarts from the MSB.
6. Hold Reset high for 10 cycles with toggling hashValue.
   - Byte=0 and Z=0 for the whole period; no transmission begins.

Source files
------------

// File: rtl/hash_transmitter_pkg.sv
// Shared constants and FSM state type for the hash byte serialiser.
package hash_transmitter_pkg;

    localparam int unsigned HASH_WIDTH = 64;
    localparam int unsigned BYTE_WIDTH = 8;
    localparam int unsigned NUM_BYTES  = HASH_WIDTH / BYTE_WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        DONE
    } state_t;

endpackage

// File: rtl/hash_transmitter.sv
// Sends a hash value MSB byte first, one byte per clock, then raises Z.
// One transmission per reset release; DONE is terminal until the next reset.
module hash_transmitter #(
    parameter int unsigned HASH_WIDTH = hash_transmitter_pkg::HASH_WIDTH,
    parameter int unsigned BYTE_WIDTH = hash_transmitter_pkg::BYTE_WIDTH
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [HASH_WIDTH-1:0] hashValue,
    output logic [BYTE_WIDTH-1:0] Byte,
    output logic                  Z
);

    import hash_transmitter_pkg::*;

    localparam int unsigned NBYTES = HASH_WIDTH / BYTE_WIDTH;
    localparam int unsigned CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBYTES - 1);

    state_t                state;
    logic [HASH_WIDTH-1:0] shreg;
    logic [CNT_W-1:0]      cnt;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    shreg <= hashValue;
                    cnt   <= '0;
                    state <= SEND;
                end
                SEND: begin
                    shreg <= shreg << BYTE_WIDTH;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST_CNT)
                        state <= DONE;
                end
                DONE: begin
                    state <= DONE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Outputs depend only on registered state, never on hashValue directly.
    assign Byte = (state == SEND) ? shreg[HASH_WIDTH-1 -: BYTE_WIDTH] : '0;
    assign Z    = (state == DONE);

endmodule

// File: tb/tb_hash_transmitter.sv
// Directed plus randomized check of the hash byte serialiser against a
// byte-extraction reference model.
module tb_hash_transmitter;

    localparam int unsigned HW = 64;
    localparam int unsigned BW = 8;
    localparam int unsigned NB = HW / BW;

    logic          Clock;
    logic          Reset;
    logic [HW-1:0] hashValue;
    logic [BW-1:0] Byte;
    logic          Z;

    int unsigned tests = 0;
    int unsigned fails = 0;

    hash_transmitter #(.HASH_WIDTH(HW), .BYTE_WIDTH(BW)) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .hashValue (hashValue),
        .Byte      (Byte),
        .Z         (Z)
    );

    initial begin
        Clock = 1'b0;
        forever #50 Clock = ~Clock;
    end

    // Reference: byte k of a transmission is the k-th byte counted from the MSB.
    function automatic logic [BW-1:0] ref_byte(input logic [HW-1:0] h, input int unsigned k);
        logic [HW-1:0] sh;
        sh = h >> (BW * (NB - 1 - k));
        return sh[BW-1:0];
    endfunction

    task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Assert reset on a falling edge, check the async clear, release one cycle later.
    task automatic pulse_reset(input logic [HW-1:0] h);
        @(negedge Clock);
        Reset     = 1'b1;
        hashValue = h;
        #1;
        check("reset_byte", Byte, '0);
        check("reset_z", {7'b0, Z}, 8'h00);
        #99;
        Reset = 1'b0;
    endtask

    // Follow a full transmission after a release; optionally scramble hashValue
    // after edge 3 and hold DONE for extra cycles.
    task automatic run_stream(input logic [HW-1:0] h, input bit scramble, input int unsigned hold);
        #1;
        check("idle_byte", Byte, '0);
        check("idle_z", {7'b0, Z}, 8'h00);
        for (int unsigned k = 0; k < NB; k++) begin
            @(posedge Clock);
            #10;
            check($sformatf("byte%0d", k), Byte, ref_byte(h, k));
            check($sformatf("send_z%0d", k), {7'b0, Z}, 8'h00);
            if (scramble && k == 2)
                hashValue = '1;
        end
        @(posedge Clock);
        #10;
        check("done_z", {7'b0, Z}, 8'h01);
        check("done_byte", Byte, '0);
        for (int unsigned c = 0; c < hold; c++) begin
            @(posedge Clock);
            hashValue = {$urandom, $urandom};
            #10;
            check("hold_z", {7'b0, Z}, 8'h01);
            check("hold_byte", Byte, '0);
        end
    endtask

    initial begin
        logic [HW-1:0] h;
        Reset     = 1'b1;
        hashValue = 64'h0000_0652_A553_28CA;
        #40;
        check("por_byte", Byte, '0);
        check("por_z", {7'b0, Z}, 8'h00);
        #40;
        Reset = 1'b0;
        run_stream(64'h0000_0652_A553_28CA, 1'b0, 2);

        pulse_reset(64'h0000_D0AB_8903_9614);
        run_stream(64'h0000_D0AB_8903_9614, 1'b0, 1);

        pulse_reset(64'h0000_D0A7_798B_0879);
        run_stream(64'h0000_D0A7_798B_0879, 1'b0, 22);

        pulse_reset(64'h0102_0304_0506_0708);
        run_stream(64'h0102_0304_0506_0708, 1'b1, 0);

        // Async reset in the middle of byte 4, between clock edges.
        pulse_reset(64'h1122_3344_5566_7788);
        repeat (4) @(posedge Clock);
        #10;
        check("pre_abort_byte", Byte, 8'h44);
        #20;
        Reset = 1'b1;
        #1;
        check("abort_byte", Byte, '0);
        check("abort_z", {7'b0, Z}, 8'h00);
        @(negedge Clock);
        Reset = 1'b0;
        run_stream(64'h1122_3344_5566_7788, 1'b0, 0);

        // Long reset with a toggling input: nothing may start.
        @(negedge Clock);
        Reset = 1'b1;
        for (int unsigned c = 0; c < 10; c++) begin
            hashValue = {$urandom, $urandom};
            @(posedge Clock);
            #10;
            check("long_rst_byte", Byte, '0);
            check("long_rst_z", {7'b0, Z}, 8'h00);
        end
        @(negedge Clock);
        Reset = 1'b0;
        h = hashValue;
        run_stream(h, 1'b0, 0);

        for (int unsigned r = 0; r < 6; r++) begin
            h = {$urandom, $urandom};
            if (r == 0) h[HW-1 -: 16] = '0;
            pulse_reset(h);
            run_stream(h, r[0], 3);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
